hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Parametrised hazard/interlock controller for the RV32I 5-stage pipeline.
- Tracks in-flight register writers behind ID in an internal slot shift register (EX, MEM, WB, ...).
- Generates the IF/ID hold, ID/EX bubble, branch flush and registered EX operand-forward selects, plus performance counters.
- Sits beside the pipeline registers. Its outputs drive PC/IF-ID enables, ID/EX and IF-ID clear, and the EX-stage operand muxes.

Parameters:
- N_SLOT, 3: number of tracked stages after ID (slot 1 = EX ... slot N_SLOT = WB); must be >= 2.
- FWD_EN, 1: 1 = forwarding mode; 0 = pure interlock mode (stall on any RAW match).
- LOAD_LAT, 1: load result unavailable for forwarding while the load is in slots 1..LOAD_LAT; range 1 to N_SLOT-1.
- CNT_W, 32: performance counter width.
- FS_W, 2: forward select width; must hold N_SLOT.

Ports:
- CLK  in  1  clock
- RST  in  1  asynchronous active-high reset
- RS1_ID  in  5  rs1 number of the instruction in ID
- RS2_ID  in  5  rs2 number of the instruction in ID
- RS1_USE_ID  in  1  instruction in ID reads rs1
- RS2_USE_ID  in  1  instruction in ID reads rs2
- RD_ID  in  5  destination of the instruction in ID
- RegWrite_ID  in  1  instruction in ID writes rd
- MemRead_ID  in  2  nonzero = load
- isBranch_E  in  1  taken branch/jump resolved in EX this cycle
- CNT_CLR  in  1  synchronous counter clear
- STALL_FD  out  1  hold PC and IF/ID
- BUBBLE_DE  out  1  load NOP into ID/EX
- FLUSH_FD  out  1  clear IF/ID
- FLUSH_DE  out  1  clear ID/EX
- FWD_A_DE  out  FS_W  EX operand A source: 0 = RF, k = result held at slot k+1 stage latch
- FWD_B_DE  out  FS_W  same for operand B
- CYC_CNT  out  CNT_W  cycles since reset/clear
- STALL_CNT  out  CNT_W  cycles with STALL_FD=1
- FLUSH_CNT  out  CNT_W  cycles with FLUSH_FD=1

Behaviour:
- Slot k holds {valid, rd, is_load}. Reset clears all slots; all outputs reset to 0.
- Match(k, rs): slot k valid, rd != 0, rd == rs, and the corresponding USE bit is set. x0 never matches.
- Stall condition:
  - FWD_EN=1: any match(k) with is_load and k <= LOAD_LAT.
  - FWD_EN=0: any match(k) for k = 1..N_SLOT. The RF is read-old-on-write, so the WB slot also interlocks.
- STALL_FD and BUBBLE_DE are combinational and equal to (stall condition AND NOT isBranch_E).
- FLUSH_FD and FLUSH_DE are combinational and equal to isBranch_E. Flush overrides stall in the same cycle.
- Slot update every clock:
  - S[k] <= S[k-1] for k >= 2.
  - S[1] <= {RegWrite_ID, RD_ID, MemRead_ID != 0} when no stall and no flush; otherwise S[1] is invalid.
  - The oldest slot drops off.
- Forward selects, FWD_EN=1 (registered at the same edge S[1] loads):
  - FWD_x_DE <= smallest k (youngest producer) with match(k, RSx_ID), else 0.
  - Forced to 0 when a bubble or flush is inserted.
  - A k that refers to a load with k <= LOAD_LAT cannot be emitted, because that case stalls.
- Forward selects, FWD_EN=0: always 0.
- Stall duration is whatever the slots dictate. LOAD_LAT=1 with a dependent instruction immediately after a load gives exactly 1 bubble. FWD_EN=0 gives up to N_SLOT bubbles.
- Counters:
  - All three increment every cycle their condition holds; they wrap modulo 2^CNT_W.
  - CNT_CLR zeroes all three at the next edge and has priority over increment.
  - CYC_CNT increments every cycle.
- Reset mid-stall or mid-flush: all slots are invalid and all outputs are 0 immediately, because the reset is asynchronous.

Test Plan:
- FWD_EN=1: `add x5,x1,x2` then `sub x6,x5,x3` -> no stall; FWD_A_DE=1 when the sub enters EX, FWD_B_DE=0.
- `lw x7,0(x1)` then `add x8,x7,x7` -> STALL_FD=BUBBLE_DE=1 for exactly 1 cycle; then FWD_A_DE=FWD_B_DE=2; STALL_CNT=1.
- Write to x0 followed by a read of x0 -> no stall, FWD=0. Producers in slots 1 and 2 both writing x9, then a read of x9 -> FWD=1 (youngest wins).
- isBranch_E=1 in the same cycle as a load-use stall -> FLUSH_FD=FLUSH_DE=1, STALL_FD=0; S[1] invalid next cycle; FLUSH_CNT increments by 1.
- FWD_EN=0, N_SLOT=3: `addi x3,x0,1` then a dependent `add x4,x3,x3` -> 3 stall cycles, then the add proceeds with FWD=0.
- Assert RST during a stall -> all outputs 0 asynchronously. CNT_CLR with CYC_CNT=100 -> 0 next cycle, then 1. CYC_CNT at 2^CNT_W-1 -> wraps to 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard/interlock controller for the RV32I 5-stage pipeline: tracks in-flight
// writers behind ID, raises load-use/RAW stalls, branch flushes and EX forward selects.
module hazard_ctrl #(
   parameter int N_SLOT   = 3,
   parameter int FWD_EN   = 1,
   parameter int LOAD_LAT = 1,
   parameter int CNT_W    = 32,
   parameter int FS_W     = 2
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic [4:0]       RS1_ID,
   input  logic [4:0]       RS2_ID,
   input  logic             RS1_USE_ID,
   input  logic             RS2_USE_ID,
   input  logic [4:0]       RD_ID,
   input  logic             RegWrite_ID,
   input  logic [1:0]       MemRead_ID,
   input  logic             isBranch_E,
   input  logic             CNT_CLR,
   output logic             STALL_FD,
   output logic             BUBBLE_DE,
   output logic             FLUSH_FD,
   output logic             FLUSH_DE,
   output logic [FS_W-1:0]  FWD_A_DE,
   output logic [FS_W-1:0]  FWD_B_DE,
   output logic [CNT_W-1:0] CYC_CNT,
   output logic [CNT_W-1:0] STALL_CNT,
   output logic [CNT_W-1:0] FLUSH_CNT
);

   typedef struct packed {
      logic       vld;
      logic [4:0] rd;
      logic       ld;
   } slot_t;

   slot_t [N_SLOT:1] slot_q, slot_d;
   logic [N_SLOT:1]  m1, m2;
   logic             stall_c, hold, flush;
   logic [FS_W-1:0]  sel_a, sel_b;
   logic [FS_W-1:0]  fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
   logic [CNT_W-1:0] cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d;

   // x0 is hardwired zero, so a writer to it never creates a dependency
   always_comb begin
      m1 = '0;
      m2 = '0;
      for (int k = 1; k <= N_SLOT; k++) begin
         m1[k] = slot_q[k].vld && (slot_q[k].rd != 5'd0) && (slot_q[k].rd == RS1_ID) && RS1_USE_ID;
         m2[k] = slot_q[k].vld && (slot_q[k].rd != 5'd0) && (slot_q[k].rd == RS2_ID) && RS2_USE_ID;
      end
   end

   always_comb begin
      stall_c = 1'b0;
      for (int k = 1; k <= N_SLOT; k++) begin
         if (FWD_EN != 0) begin
            if ((m1[k] || m2[k]) && slot_q[k].ld && (k <= LOAD_LAT)) stall_c = 1'b1;
         end else begin
            if (m1[k] || m2[k]) stall_c = 1'b1;
         end
      end
   end

   // Scan oldest to youngest so the youngest producer overwrites the select
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int k = N_SLOT; k >= 1; k--) begin
         if (m1[k]) sel_a = FS_W'(k);
         if (m2[k]) sel_b = FS_W'(k);
      end
   end

   // Flush is gated by reset so every output reads 0 while RST is held
   assign flush     = isBranch_E && !RST;
   assign hold      = stall_c && !isBranch_E;
   assign STALL_FD  = hold;
   assign BUBBLE_DE = hold;
   assign FLUSH_FD  = flush;
   assign FLUSH_DE  = flush;
   assign FWD_A_DE  = fwd_a_q;
   assign FWD_B_DE  = fwd_b_q;
   assign CYC_CNT   = cyc_q;
   assign STALL_CNT = stl_q;
   assign FLUSH_CNT = fls_q;

   always_comb begin
      slot_d = slot_q;
      for (int k = N_SLOT; k >= 2; k--) slot_d[k] = slot_q[k-1];
      slot_d[1].vld = RegWrite_ID && !stall_c && !isBranch_E;
      slot_d[1].rd  = RD_ID;
      slot_d[1].ld  = (MemRead_ID != 2'd0);
   end

   always_comb begin
      fwd_a_d = '0;
      fwd_b_d = '0;
      if ((FWD_EN != 0) && !stall_c && !isBranch_E) begin
         fwd_a_d = sel_a;
         fwd_b_d = sel_b;
      end
   end

   always_comb begin
      cyc_d = cyc_q + CNT_W'(1);
      stl_d = hold  ? stl_q + CNT_W'(1) : stl_q;
      fls_d = flush ? fls_q + CNT_W'(1) : fls_q;
      if (CNT_CLR) begin
         cyc_d = '0;
         stl_d = '0;
         fls_d = '0;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         slot_q  <= '0;
         fwd_a_q <= '0;
         fwd_b_q <= '0;
         cyc_q   <= '0;
         stl_q   <= '0;
         fls_q   <= '0;
      end else begin
         slot_q  <= slot_d;
         fwd_a_q <= fwd_a_d;
         fwd_b_q <= fwd_b_d;
         cyc_q   <= cyc_d;
         stl_q   <= stl_d;
         fls_q   <= fls_d;
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench: a forwarding-mode instance (A) and an interlock-mode instance
// with 8-bit counters (B); stimulus queues expectations, a monitor pops and compares.
module tb_hazard_ctrl;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] rd;
      logic       rw;
      logic [1:0] mr;
      logic       br;
      logic       clr;
   } id_t;

   id_t ia, ib;

   logic        sa, ba, ffa, fda;
   logic [1:0]  fwa_a, fwb_a;
   logic [31:0] cyc_a, stl_a, fls_a;
   logic        sb, bb, ffb, fdb;
   logic [1:0]  fwa_b, fwb_b;
   logic [7:0]  cyc_b, stl_b, fls_b;

   hazard_ctrl #(.N_SLOT(3), .FWD_EN(1), .LOAD_LAT(1), .CNT_W(32), .FS_W(2)) u_a (
      .CLK(CLK), .RST(RST),
      .RS1_ID(ia.rs1), .RS2_ID(ia.rs2), .RS1_USE_ID(ia.u1), .RS2_USE_ID(ia.u2),
      .RD_ID(ia.rd), .RegWrite_ID(ia.rw), .MemRead_ID(ia.mr), .isBranch_E(ia.br),
      .CNT_CLR(ia.clr),
      .STALL_FD(sa), .BUBBLE_DE(ba), .FLUSH_FD(ffa), .FLUSH_DE(fda),
      .FWD_A_DE(fwa_a), .FWD_B_DE(fwb_a),
      .CYC_CNT(cyc_a), .STALL_CNT(stl_a), .FLUSH_CNT(fls_a)
   );

   hazard_ctrl #(.N_SLOT(3), .FWD_EN(0), .LOAD_LAT(1), .CNT_W(8), .FS_W(2)) u_b (
      .CLK(CLK), .RST(RST),
      .RS1_ID(ib.rs1), .RS2_ID(ib.rs2), .RS1_USE_ID(ib.u1), .RS2_USE_ID(ib.u2),
      .RD_ID(ib.rd), .RegWrite_ID(ib.rw), .MemRead_ID(ib.mr), .isBranch_E(ib.br),
      .CNT_CLR(ib.clr),
      .STALL_FD(sb), .BUBBLE_DE(bb), .FLUSH_FD(ffb), .FLUSH_DE(fdb),
      .FWD_A_DE(fwa_b), .FWD_B_DE(fwb_b),
      .CYC_CNT(cyc_b), .STALL_CNT(stl_b), .FLUSH_CNT(fls_b)
   );

   // ctl packs {stall, bubble, flush_fd, flush_de, fwd_a[1:0], fwd_b[1:0]}
   typedef struct {
      string       name;
      bit          dut;
      logic [7:0]  ctl;
      bit   [2:0]  cm;
      logic [31:0] cyc;
      logic [31:0] stl;
      logic [31:0] fls;
   } exp_t;

   exp_t q[$];
   int n_run  = 0;
   int n_fail = 0;

   always @(negedge CLK or posedge RST) begin
      exp_t        e;
      logic [7:0]  act;
      logic [31:0] c, s, f;
      #1;
      while (q.size() > 0) begin
         e = q.pop_front();
         if (!e.dut) begin
            act = {sa, ba, ffa, fda, fwa_a, fwb_a};
            c = cyc_a; s = stl_a; f = fls_a;
         end else begin
            act = {sb, bb, ffb, fdb, fwa_b, fwb_b};
            c = {24'd0, cyc_b}; s = {24'd0, stl_b}; f = {24'd0, fls_b};
         end
         n_run++;
         if (act !== e.ctl || (e.cm[2] && c !== e.cyc) || (e.cm[1] && s !== e.stl) ||
             (e.cm[0] && f !== e.fls)) begin
            n_fail++;
            $display("FAIL %s: got ctl=%b cyc=%0d stl=%0d fls=%0d, want ctl=%b cyc=%0d stl=%0d fls=%0d (cnt mask %b)",
                     e.name, act, c, s, f, e.ctl, e.cyc, e.stl, e.fls, e.cm);
         end
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic exp_cnt(input string nm, input bit d, input logic [7:0] ctl, input bit [2:0] cm,
                          input logic [31:0] cy, input logic [31:0] st, input logic [31:0] fl);
      exp_t e;
      e.name = nm; e.dut = d; e.ctl = ctl; e.cm = cm; e.cyc = cy; e.stl = st; e.fls = fl;
      q.push_back(e);
   endtask

   task automatic exp_ctl(input string nm, input bit d, input logic [7:0] ctl);
      exp_cnt(nm, d, ctl, 3'b000, 32'd0, 32'd0, 32'd0);
   endtask

   function automatic id_t ins(input logic [4:0] rd, input logic [1:0] mr, input logic [4:0] r1,
                               input logic u1, input logic [4:0] r2, input logic u2);
      id_t r = '0;
      r.rd = rd; r.rw = 1'b1; r.mr = mr;
      r.rs1 = r1; r.u1 = u1; r.rs2 = r2; r.u2 = u2;
      return r;
   endfunction

   initial begin
      ia = '0;
      ib = '0;
      tick();
      exp_cnt("rst_a", 1'b0, 8'h00, 3'b111, 0, 0, 0);
      exp_cnt("rst_b", 1'b1, 8'h00, 3'b111, 0, 0, 0);
      tick();
      RST = 1'b0;

      // add x5,x1,x2 ; sub x6,x5,x3
      ia = ins(5, 2'd0, 1, 1'b1, 2, 1'b1);  exp_ctl("alu_prod", 1'b0, 8'h00);   tick();
      ia = ins(6, 2'd0, 5, 1'b1, 3, 1'b1);  exp_ctl("alu_cons", 1'b0, 8'h00);   tick();
      ia = '0;                              exp_ctl("alu_fwd1", 1'b0, 8'h04);   tick();
      ia = '0; ia.clr = 1'b1;               exp_ctl("fwd_clear", 1'b0, 8'h00);  tick();

      // lw x7,0(x1) ; add x8,x7,x7
      ia = ins(7, 2'd1, 1, 1'b1, 0, 1'b0);  exp_cnt("lu_load", 1'b0, 8'h00, 3'b111, 0, 0, 0); tick();
      ia = ins(8, 2'd0, 7, 1'b1, 7, 1'b1);  exp_ctl("lu_stall", 1'b0, 8'hC0);   tick();
      exp_ctl("lu_release", 1'b0, 8'h00);                                        tick();
      ia = '0;                              exp_cnt("lu_fwd2", 1'b0, 8'h0A, 3'b111, 3, 1, 0); tick();
      repeat (3) tick();

      // write x0 then read x0
      ia = ins(0, 2'd0, 1, 1'b1, 0, 1'b0);                                       tick();
      ia = ins(11, 2'd0, 0, 1'b1, 0, 1'b1); exp_ctl("x0_nostall", 1'b0, 8'h00); tick();
      ia = '0;                              exp_ctl("x0_fwd", 1'b0, 8'h00);     tick();

      // two writers of x9, then a reader: youngest wins
      ia = ins(9, 2'd0, 1, 1'b1, 0, 1'b0);                                       tick();
      ia = ins(9, 2'd0, 1, 1'b1, 0, 1'b0);                                       tick();
      ia = ins(10, 2'd0, 9, 1'b1, 9, 1'b1); exp_ctl("x9_nostall", 1'b0, 8'h00); tick();
      ia = '0;                              exp_ctl("x9_youngest", 1'b0, 8'h05); tick();

      // taken branch in the same cycle as a load-use stall
      ia = ins(7, 2'd1, 1, 1'b1, 0, 1'b0);                                       tick();
      ia = ins(8, 2'd0, 7, 1'b1, 7, 1'b1); ia.br = 1'b1;
      exp_ctl("br_over_stall", 1'b0, 8'h30);                                     tick();
      ia = ins(12, 2'd0, 8, 1'b1, 7, 1'b1); exp_ctl("br_s1_inval", 1'b0, 8'h00); tick();
      ia = '0;                              exp_cnt("br_fwd_cnt", 1'b0, 8'h02, 3'b011, 0, 1, 1); tick();

      // interlock mode: addi x3,x0,1 ; add x4,x3,x3
      ib = ins(3, 2'd0, 0, 1'b1, 0, 1'b0);  exp_ctl("il_prod", 1'b1, 8'h00);    tick();
      ib = ins(4, 2'd0, 3, 1'b1, 3, 1'b1);
      exp_ctl("il_stall1", 1'b1, 8'hC0);                                         tick();
      exp_ctl("il_stall2", 1'b1, 8'hC0);                                         tick();
      exp_ctl("il_stall3", 1'b1, 8'hC0);                                         tick();
      exp_ctl("il_go", 1'b1, 8'h00);                                             tick();
      ib = '0;                              exp_cnt("il_fwd0", 1'b1, 8'h00, 3'b010, 0, 3, 0); tick();

      // async reset while B stalls and A flushes
      ib = ins(3, 2'd0, 0, 1'b1, 0, 1'b0);                                       tick();
      ib = ins(4, 2'd0, 3, 1'b1, 3, 1'b1);
      ia = '0; ia.br = 1'b1;
      exp_ctl("rst_pre_b", 1'b1, 8'hC0);
      exp_ctl("rst_pre_a", 1'b0, 8'h30);
      @(negedge CLK);
      #2;
      exp_cnt("rst_async_a", 1'b0, 8'h00, 3'b111, 0, 0, 0);
      exp_cnt("rst_async_b", 1'b1, 8'h00, 3'b111, 0, 0, 0);
      RST = 1'b1;
      tick();
      ia = '0;
      ib = '0;
      tick();
      RST = 1'b0;

      // counter clear at CYC_CNT=100
      repeat (100) tick();
      ia.clr = 1'b1;  exp_cnt("clr_at100", 1'b0, 8'h00, 3'b100, 100, 0, 0); tick();
      ia.clr = 1'b0;  exp_cnt("clr_zero",  1'b0, 8'h00, 3'b111, 0, 0, 0);   tick();
      exp_cnt("clr_then1", 1'b0, 8'h00, 3'b100, 1, 0, 0);                    tick();

      // 8-bit cycle counter wrap on B
      repeat (152) tick();
      exp_cnt("wrap_255", 1'b1, 8'h00, 3'b111, 255, 0, 0);                   tick();
      exp_cnt("wrap_0",   1'b1, 8'h00, 3'b100, 0, 0, 0);                     tick();

      tick();
      if (q.size() != 0) begin
         n_run++;
         n_fail++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
